mem_stage: RTL and testbench

//  Memory-access stage of the 5-stage pipeline, directly downstream of the EX/MEM register.

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/data_ram.sv | 24 ++
 rtl/mem_stage.sv | 125 ++++++++++++
 tb/tb_mem_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: control-bit positions inside the WB/M
// bundles, the memory-stage state encoding and the illegal-access rule.
package pipeline_pkg;

   // WB bundle bit positions
   localparam int WB_REGWRITE = 1;
   localparam int WB_MEMTOREG = 0;

   // M bundle bit positions
   localparam int M_BRANCH   = 2;
   localparam int M_MEMREAD  = 1;
   localparam int M_MEMWRITE = 0;

   // Memory-stage FSM encoding
   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } mem_state_t;

   // An access is illegal when it is misaligned, or when it asks for
   // read and write at the same time.
   function automatic logic is_illegal(input logic [2:0] m, input logic [1:0] addr_lo);
      logic memop;
      memop = m[M_MEMREAD] | m[M_MEMWRITE];
      return (memop && (addr_lo != 2'b00)) || (m[M_MEMREAD] && m[M_MEMWRITE]);
   endfunction

endpackage

// File: rtl/data_ram.sv
// Word-addressed data RAM: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module data_ram #(
   parameter int ADDR_BITS = 8
) (
   input  logic                 Clock,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata
);

   logic [31:0] mem [0:(2**ADDR_BITS)-1];

   // Write port: commits on the clock edge when enabled
   always_ff @(posedge Clock) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: holds the pipeline with Stall while a load/store
// waits out MEM_LATENCY cycles, then performs the access and fills the
// MEM/WB register.
//
// Handshake: Stall is combinational. While Stall=1 the upstream EX/MEM
// register holds its contents unchanged and this stage emits bubbles; the
// cycle in which Stall=0 is the one whose inputs are consumed at the next
// edge (commit cycle for memory ops, plain pass-through otherwise).
module mem_stage
   import pipeline_pkg::*;
#(
   parameter int ADDR_BITS   = 8,
   parameter int MEM_LATENCY = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [1:0]  WB,
   input  logic [2:0]  M,
   input  logic [4:0]  RD,
   input  logic [31:0] saidaALU,
   input  logic [31:0] saidaData,
   output logic        Stall,
   output logic        Erro,
   output logic [1:0]  registradorWB,
   output logic [31:0] dadoMemoria,
   output logic [31:0] registradorALU,
   output logic [4:0]  registradorRD,
   output mem_state_t  state_dbg
);

   localparam logic [3:0] LAT_M1 = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

   mem_state_t           state, next_state;
   logic [3:0]           cnt, next_cnt;
   logic                 memop;
   logic                 commit;
   logic                 bubble;
   logic                 illegal;
   logic                 ram_we;
   logic                 load_ok;
   logic [ADDR_BITS-1:0] idx;
   logic [31:0]          ram_rdata;
   logic                 unused_branch;

   assign memop         = M[M_MEMREAD] | M[M_MEMWRITE];
   assign idx           = saidaALU[ADDR_BITS+1:2];
   assign unused_branch = M[M_BRANCH];
   assign state_dbg     = state;

   // Next-state, stall and commit decode
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      Stall      = 1'b0;
      bubble     = 1'b0;
      commit     = 1'b0;
      unique case (state)
         IDLE: begin
            if (memop) begin
               if (MEM_LATENCY > 0) begin
                  Stall      = 1'b1;
                  bubble     = 1'b1;
                  next_state = BUSY;
                  next_cnt   = LAT_M1;
               end else begin
                  commit = 1'b1;
               end
            end
         end
         BUSY: begin
            if (cnt != 4'd0) begin
               Stall    = 1'b1;
               bubble   = 1'b1;
               next_cnt = cnt - 4'd1;
            end else begin
               commit     = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Illegal accesses are only judged on the commit cycle's inputs
   assign illegal = commit & is_illegal(M, saidaALU[1:0]);
   assign ram_we  = commit & M[M_MEMWRITE] & ~illegal;
   assign load_ok = commit & M[M_MEMREAD] & ~illegal;

   data_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
      .Clock (Clock),
      .we    (ram_we),
      .addr  (idx),
      .wdata (saidaData),
      .rdata (ram_rdata)
   );

   // FSM state, counter and MEM/WB register
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state          <= IDLE;
         cnt            <= 4'd0;
         Erro           <= 1'b0;
         registradorWB  <= 2'b00;
         dadoMemoria    <= 32'd0;
         registradorALU <= 32'd0;
         registradorRD  <= 5'd0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
         Erro  <= illegal;
         if (bubble) begin
            registradorWB  <= 2'b00;
            dadoMemoria    <= 32'd0;
            registradorALU <= 32'd0;
            registradorRD  <= 5'd0;
         end else begin
            registradorWB  <= WB;
            registradorALU <= saidaALU;
            registradorRD  <= RD;
            dadoMemoria    <= load_ok ? ram_rdata : 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: a MEM_LATENCY=2 instance for the main scenarios and
// a MEM_LATENCY=0 instance for the single-cycle/wrap scenario.
module tb_mem_stage;
   import pipeline_pkg::*;

   localparam int AB = 8;

   // clock / reset
   logic Clock = 1'b0;
   always #5 Clock = ~Clock;
   logic Reset;

   // MEM_LATENCY=2 instance signals
   logic [1:0]  WB;
   logic [2:0]  M;
   logic [4:0]  RD;
   logic [31:0] saidaALU, saidaData;
   logic        Stall, Erro;
   logic [1:0]  registradorWB;
   logic [31:0] dadoMemoria, registradorALU;
   logic [4:0]  registradorRD;
   mem_state_t  state_dbg;

   // MEM_LATENCY=0 instance signals
   logic [1:0]  z_WB;
   logic [2:0]  z_M;
   logic [4:0]  z_RD;
   logic [31:0] z_saidaALU, z_saidaData;
   logic        z_Stall, z_Erro;
   logic [1:0]  z_registradorWB;
   logic [31:0] z_dadoMemoria, z_registradorALU;
   logic [4:0]  z_registradorRD;
   mem_state_t  z_state_dbg;

   mem_stage #(.ADDR_BITS(AB), .MEM_LATENCY(2)) dut (
      .Clock(Clock), .Reset(Reset), .WB(WB), .M(M), .RD(RD),
      .saidaALU(saidaALU), .saidaData(saidaData), .Stall(Stall), .Erro(Erro),
      .registradorWB(registradorWB), .dadoMemoria(dadoMemoria),
      .registradorALU(registradorALU), .registradorRD(registradorRD),
      .state_dbg(state_dbg)
   );

   mem_stage #(.ADDR_BITS(AB), .MEM_LATENCY(0)) dut0 (
      .Clock(Clock), .Reset(Reset), .WB(z_WB), .M(z_M), .RD(z_RD),
      .saidaALU(z_saidaALU), .saidaData(z_saidaData), .Stall(z_Stall), .Erro(z_Erro),
      .registradorWB(z_registradorWB), .dadoMemoria(z_dadoMemoria),
      .registradorALU(z_registradorALU), .registradorRD(z_registradorRD),
      .state_dbg(z_state_dbg)
   );

   // scoreboard: packed {Erro, WB, RD, ALU, data}
   logic [71:0] exp_q[$];
   logic [31:0] ref_mem  [0:(2**AB)-1];
   logic [31:0] ref_mem0 [0:(2**AB)-1];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [71:0] pack(input logic erro, input logic [1:0] wb, input logic [4:0] rd,
                                        input logic [31:0] alu, input logic [31:0] data);
      return {erro, wb, rd, alu, data};
   endfunction

   // driver: one cycle on the latency-2 instance (entered at posedge+1)
   task automatic cycle2(input string tag, input logic [1:0] wb, input logic [2:0] m,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] data,
                         input logic exp_stall, input logic [71:0] exp_out);
      WB = wb; M = m; RD = rd; saidaALU = alu; saidaData = data;
      #1;
      check({tag, " stall"}, 72'(Stall), 72'(exp_stall));
      exp_q.push_back(exp_out);
      @(posedge Clock);
      #1;
      check(tag, {Erro, registradorWB, registradorRD, registradorALU, dadoMemoria}, exp_q.pop_front());
   endtask

   // driver: a complete operation on the latency-2 instance
   task automatic op2(input string tag, input logic [1:0] wb, input logic [2:0] m,
                      input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] data);
      logic memop, bad;
      logic [31:0] exp_data;
      memop = m[1] | m[0];
      bad   = memop && ((alu[1:0] != 2'b00) || (m[1] && m[0]));
      if (memop) begin
         cycle2({tag, " s1"}, wb, m, rd, alu, data, 1'b1, 72'd0);
         cycle2({tag, " s2"}, wb, m, rd, alu, data, 1'b1, 72'd0);
      end
      exp_data = (m[1] && !bad) ? ref_mem[alu[AB+1:2]] : 32'd0;
      if (m[0] && !bad) ref_mem[alu[AB+1:2]] = data;
      cycle2(tag, wb, m, rd, alu, data, 1'b0, pack(bad, wb, rd, alu, exp_data));
   endtask

   // driver: a complete operation on the latency-0 instance
   task automatic op0(input string tag, input logic [1:0] wb, input logic [2:0] m,
                      input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] data);
      logic bad;
      logic [31:0] exp_data;
      bad = (m[1] | m[0]) && ((alu[1:0] != 2'b00) || (m[1] && m[0]));
      exp_data = (m[1] && !bad) ? ref_mem0[alu[AB+1:2]] : 32'd0;
      if (m[0] && !bad) ref_mem0[alu[AB+1:2]] = data;
      z_WB = wb; z_M = m; z_RD = rd; z_saidaALU = alu; z_saidaData = data;
      #1;
      check({tag, " stall"}, 72'(z_Stall), 72'd0);
      exp_q.push_back(pack(bad, wb, rd, alu, exp_data));
      @(posedge Clock);
      #1;
      check(tag, {z_Erro, z_registradorWB, z_registradorRD, z_registradorALU, z_dadoMemoria}, exp_q.pop_front());
      z_M = 3'b000;
   endtask

   initial begin
      logic [31:0] a, d;
      Reset = 1'b1;
      WB = 0; M = 0; RD = 0; saidaALU = 0; saidaData = 0;
      z_WB = 0; z_M = 0; z_RD = 0; z_saidaALU = 0; z_saidaData = 0;
      repeat (2) @(posedge Clock);
      #1;
      check("reset out", {Erro, registradorWB, registradorRD, registradorALU, dadoMemoria}, 72'd0);
      check("reset state", 72'(state_dbg), 72'(IDLE));
      Reset = 1'b0;

      // ALU pass-through, no stall
      op2("t1 alu", 2'b10, 3'b000, 5'd5, 32'h1234, 32'h0);
      op2("t1 alu2", 2'b11, 3'b000, 5'd31, 32'hFFFF_0003, 32'h1);

      // store then back-to-back load
      op2("t2 st", 2'b00, 3'b001, 5'd0, 32'h8, 32'hDEADBEEF);
      op2("t2 ld", 2'b11, 3'b010, 5'd9, 32'h8, 32'h0);

      // misaligned load and misaligned store
      op2("t3 ld mis", 2'b11, 3'b010, 5'd3, 32'h6, 32'h0);
      op2("t3 st mis", 2'b00, 3'b001, 5'd0, 32'hA, 32'h77);
      op2("t3 ld chk", 2'b11, 3'b010, 5'd4, 32'h8, 32'h0);

      // read+write together
      op2("t6 st", 2'b00, 3'b001, 5'd0, 32'h20, 32'h55555555);
      op2("t6 rw", 2'b10, 3'b011, 5'd6, 32'h20, 32'h66666666);
      op2("t6 ld", 2'b11, 3'b010, 5'd7, 32'h20, 32'h0);

      // reset aborts an in-flight store
      op2("t4 pre", 2'b00, 3'b001, 5'd0, 32'h10, 32'h11111111);
      cycle2("t4 s1", 2'b00, 3'b001, 5'd0, 32'h10, 32'h22222222, 1'b1, 72'd0);
      #1;
      check("t4 s2 stall", 72'(Stall), 72'd1);
      check("t4 busy", 72'(state_dbg), 72'(BUSY));
      #1;
      Reset = 1'b1;
      M = 3'b000;
      #1;
      check("t4 rst out", {Erro, registradorWB, registradorRD, registradorALU, dadoMemoria}, 72'd0);
      check("t4 rst state", 72'(state_dbg), 72'(IDLE));
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      op2("t4 ld", 2'b11, 3'b010, 5'd8, 32'h10, 32'h0);

      // random aligned store/load pairs
      for (int i = 0; i < 4; i++) begin
         a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         d = $urandom;
         op2("rnd st", 2'b00, 3'b001, 5'd0, a, d);
         op2("rnd ld", 2'b11, 3'b010, 5'($urandom_range(1, 31)), a, 32'h0);
      end
      op2("end nop", 2'b00, 3'b000, 5'd0, 32'h0, 32'h0);

      // single-cycle access with address wrap
      op0("t5 st", 2'b00, 3'b001, 5'd0, 32'h404, 32'hCAFEF00D);
      op0("t5 ld", 2'b11, 3'b010, 5'd2, 32'h404, 32'h0);
      op0("t5 ld wrap", 2'b11, 3'b010, 5'd3, 32'h4, 32'h0);
      op0("t5 mis", 2'b11, 3'b010, 5'd4, 32'h5, 32'h0);
      op0("t5 nop", 2'b10, 3'b000, 5'd1, 32'h99, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
